conv: RTL and testbench

CONV -- requirements
Module: conv

---
 rtl/conv.sv | 102 ++++++++++
 tb/tb_conv.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/conv.sv
// conv: 5x5 binary-weight (+1/-1) convolution over a raster stream of taps columns.
// Define CONV_RELU_EN to clamp negative truncated results to zero.
module conv #(
    parameter int DATA_W = 32,
    parameter int K      = 5,
    parameter int SKIP   = 11
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  weight_en,
    input  logic                  weight,
    input  logic [K*DATA_W-1:0]   taps,
    input  logic                  state,
    output logic [DATA_W-1:0]     dout,
    output logic                  ovalid,
    output logic                  done
);
    localparam int AW = DATA_W + 5;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RUN = 2'd2, FIN = 2'd3;
    logic [1:0] st;
    logic start_d, wid, valid_p, last_p;
    logic [7:0] sk;
    logic [4:0] x, y, wcnt, xmax;
    logic [K*K-1:0] w;
    logic [K*DATA_W-1:0] col [K];
    logic signed [AW-1:0] sum;
    logic [DATA_W-1:0] res;
    assign xmax = wid ? 5'd11 : 5'd27;
    always_comb begin
        sum = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                sum = w[K*i+j]
                    ? sum + {{5{col[j][DATA_W*i+DATA_W-1]}}, col[j][DATA_W*i +: DATA_W]}
                    : sum - {{5{col[j][DATA_W*i+DATA_W-1]}}, col[j][DATA_W*i +: DATA_W]};
`ifdef CONV_RELU_EN
        res = sum[DATA_W-1] ? '0 : sum[DATA_W-1:0];
`else
        res = sum[DATA_W-1:0];
`endif
    end
    always_ff @(posedge clk) begin
        if (rstn) begin
            st <= IDLE;
            start_d <= 1'b0;
            wid <= 1'b0;
            sk <= '0;
            x <= '0;
            y <= '0;
            w <= '0;
            wcnt <= '0;
            valid_p <= 1'b0;
            last_p <= 1'b0;
            dout <= '0;
            ovalid <= 1'b0;
            done <= 1'b0;
            for (int k = 0; k < K; k++) col[k] <= '0;
        end else begin
            start_d <= start;
            if (weight_en && wcnt < 5'(K*K)) begin
                w[wcnt] <= weight;
                wcnt <= wcnt + 5'd1;
            end
            dout <= valid_p ? res : dout;
            ovalid <= valid_p;
            done <= last_p;
            valid_p <= 1'b0;
            last_p <= 1'b0;
            // Dropping start aborts the frame, including any result still in the pipe
            if (!start) begin
                st <= IDLE;
                x <= '0;
                y <= '0;
                ovalid <= 1'b0;
                done <= 1'b0;
            end else begin
                case (st)
                    IDLE: if (!start_d) begin
                        wid <= state;
                        sk <= 8'd1;
                        st <= WAIT;
                    end
                    WAIT: begin
                        st <= (sk == 8'(SKIP-1)) ? RUN : WAIT;
                        sk <= sk + 8'd1;
                    end
                    RUN: begin
                        for (int k = 0; k < K-1; k++) col[k] <= col[k+1];
                        col[K-1] <= taps;
                        valid_p <= x >= 5'(K-1) && y >= 5'(K-1);
                        last_p <= x == xmax && y == xmax;
                        x <= (x == xmax) ? 5'd0 : x + 5'd1;
                        y <= (x == xmax) ? y + 5'd1 : y;
                        st <= (x == xmax && y == xmax) ? FIN : RUN;
                    end
                    default: st <= FIN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv.sv
// tb_conv: randomized frames checked against a direct 5x5 window-sum model of the image.
module tb_conv;
    localparam int DW = 32, K = 5, SKIP = 11;
    logic clk = 1'b0, rstn, start, weight_en, weight, state;
    logic [K*DW-1:0] taps;
    logic [DW-1:0] dout;
    logic ovalid, done;
    int n_cmp = 0, n_err = 0;
    bit wk [25];
    logic signed [DW-1:0] img [28][28];

    conv #(.DATA_W(DW), .K(K), .SKIP(SKIP)) dut (
        .clk(clk), .rstn(rstn), .start(start), .weight_en(weight_en), .weight(weight),
        .taps(taps), .state(state), .dout(dout), .ovalid(ovalid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] win(input int ox, input int oy);
        longint s = 0;
        logic [DW-1:0] t;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += wk[K*i+j] ? longint'(img[oy+i][ox+j]) : -longint'(img[oy+i][ox+j]);
        t = s[DW-1:0];
`ifdef CONV_RELU_EN
        if (t[DW-1]) t = '0;
`endif
        return t;
    endfunction

    // mode: 0 random bits, 1 all +1, 2 all -1; a few extra strobes must be ignored
    task automatic load_w(input int mode);
        for (int n = 0; n < 25; n++) begin
            wk[n] = (mode == 0) ? 1'($urandom % 2) : (mode == 1);
            @(negedge clk);
            weight_en = 1'b1;
            weight = wk[n];
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            weight = ~wk[n];
        end
        @(negedge clk);
        weight_en = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_dout", dout, 0);
        check("rst_ovalid", ovalid, 0);
        check("rst_done", done, 0);
    endtask

    // mode: 0 random pixels, 1 pixel=x, 2 all 2, 3 all 1; abort_at<0 runs the full frame
    task automatic run_frame(input bit st, input int mode, input int abort_at);
        int w, nout, total, seen, x, y, i, row;
        bit ev [1100];
        bit ed [1100];
        logic [DW-1:0] eo [1100];
        bit ab;
        w = st ? 12 : 28;
        nout = (w - 4) * (w - 4);
        total = SKIP + w * w + 4;
        seen = 0;
        ab = 1'b0;
        for (int r = 0; r < w; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = (mode == 0) ? DW'($urandom) : (mode == 1) ? DW'(c) : (mode == 2) ? 2 : 1;
        @(negedge clk);
        start = 1'b1;
        state = st;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            check("ovalid", ovalid, ev[k] && !ab);
            check("done", done, ed[k] && !ab);
            if (ev[k] && !ab) check("dout", dout, eo[k]);
            if (ovalid) seen++;
            if (ab && k > abort_at + 3) break;
            state = 1'($urandom % 2);
            if (k == abort_at) begin
                start = 1'b0;
                ab = 1'b1;
            end
            i = k - SKIP;
            if (i >= 0 && i < w * w) begin
                x = i % w;
                y = i / w;
                for (int r = 0; r < K; r++) begin
                    row = y - 4 + r;
                    taps[DW*r +: DW] = (row >= 0) ? img[row][x] : DW'($urandom);
                end
                if (x >= 4 && y >= 4) begin
                    ev[k+2] = 1'b1;
                    eo[k+2] = win(x - 4, y - 4);
                    ed[k+2] = ((y - 4) * (w - 4) + (x - 4)) == nout - 1;
                end
            end else begin
                for (int r = 0; r < K; r++) taps[DW*r +: DW] = DW'($urandom);
            end
        end
        if (!ab) check("count", seen, nout);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b1;
        start = 1'b1;
        weight_en = 1'b1;
        weight = 1'b1;
        state = 1'b0;
        taps = '0;
        repeat (3) @(negedge clk);
        check_reset();
        rstn = 1'b0;
        start = 1'b0;
        weight_en = 1'b0;
        load_w(0);
        run_frame(1'b1, 0, -1);
        run_frame(1'b0, 0, -1);
        run_frame(1'b1, 0, SKIP + 12 * 6 + 8);
        run_frame(1'b1, 0, -1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        check_reset();
        load_w(2);
        run_frame(1'b0, 3, -1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        check_reset();
        load_w(1);
        run_frame(1'b0, 1, -1);
        run_frame(1'b1, 2, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
